// File: rtl/tuner_multi_seq.sv
// Sequencer for cascaded microring tuners on one WDM bus:
// search, pick a peak, program, lock, then move downstream.
module tuner_multi_seq #(
   parameter int NUM_CH     = 4,
   parameter int DAC_WIDTH  = 8,
   parameter int ADC_WIDTH  = 8,
   parameter int NUM_TARGET = 8,
   parameter int TMO_WIDTH  = 16,
   localparam int CW = $clog2(NUM_TARGET) + 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_start,
   input  logic [NUM_CH-1:0]                    i_cfg_ch_en,
   input  logic                                 i_cfg_mode,
   input  logic [TMO_WIDTH-1:0]                 i_cfg_tmo,
   output logic [NUM_CH-1:0]                    o_search_trig_val,
   input  logic [NUM_CH-1:0]                    i_search_trig_rdy,
   input  logic [NUM_CH-1:0]                    i_search_done_val,
   output logic [NUM_CH-1:0]                    o_search_done_rdy,
   input  logic [NUM_CH*NUM_TARGET*DAC_WIDTH-1:0] i_peak_tune,
   input  logic [NUM_CH*NUM_TARGET*ADC_WIDTH-1:0] i_peak_pwr,
   input  logic [NUM_CH*CW-1:0]                 i_num_peaks,
   output logic [NUM_CH-1:0]                    o_lock_trig_val,
   input  logic [NUM_CH-1:0]                    i_lock_trig_rdy,
   input  logic [NUM_CH-1:0]                    i_lock_track_val,
   output logic [NUM_CH-1:0]                    o_lock_track_rdy,
   output logic [NUM_CH*ADC_WIDTH-1:0]          o_cfg_pwr_peak,
   output logic [NUM_CH*DAC_WIDTH-1:0]          o_cfg_ring_tune_peak,
   output logic [NUM_CH-1:0]                    o_ch_locked,
   output logic [NUM_CH-1:0]                    o_ch_err,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err
);

   localparam int IW  = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW  = $clog2(NUM_CH + 1);

   typedef enum logic [2:0] {
      IDLE, S_TRIG, S_WAIT, SELECT, L_TRIG, L_WAIT, NEXT, DONE
   } state_e;

   state_e                 state_q;
   logic [PW-1:0]          ptr_q;
   logic [TMO_WIDTH-1:0]   tmo_cnt_q;
   logic [IW-1:0]          idx_q;
   logic [IW-1:0]          best_q;
   logic [CW-1:0]          cnt_q;
   logic                   sel_done_q;
   logic [DAC_WIDTH-1:0]   tune_q [NUM_TARGET];
   logic [ADC_WIDTH-1:0]   pwr_q  [NUM_TARGET];
   logic [NUM_CH-1:0]      s_val_q, s_rdy_q, l_val_q, trk_q;
   logic [NUM_CH-1:0]      locked_q, ch_err_q;
   logic [NUM_CH*ADC_WIDTH-1:0] cfg_pwr_q;
   logic [NUM_CH*DAC_WIDTH-1:0] cfg_tune_q;
   logic                   busy_q, done_q, err_q;

   logic [CHW-1:0]         ch;
   logic [DAC_WIDTH-1:0]   in_tune [NUM_TARGET];
   logic [ADC_WIDTH-1:0]   in_pwr  [NUM_TARGET];
   logic [IW-1:0]          best_d;
   logic                   sel_last, cnt_bad, tmo_hit;

   assign ch = ptr_q[CHW-1:0];

   always_comb begin
      for (int k = 0; k < NUM_TARGET; k++) begin
         in_tune[k] = i_peak_tune[(int'(ch)*NUM_TARGET + k)*DAC_WIDTH +: DAC_WIDTH];
         in_pwr[k]  = i_peak_pwr[(int'(ch)*NUM_TARGET + k)*ADC_WIDTH +: ADC_WIDTH];
      end
   end

   // strict compare keeps the lower index on equal power
   always_comb begin
      best_d = best_q;
      if (idx_q == '0 || pwr_q[idx_q] > pwr_q[best_q])
         best_d = idx_q;
   end

   assign sel_last = i_cfg_mode || ({1'b0, idx_q} == cnt_q - 1'b1);
   assign cnt_bad  = (cnt_q == '0) || (cnt_q > CW'(NUM_TARGET));
   assign tmo_hit  = (i_cfg_tmo != '0) && (tmo_cnt_q == i_cfg_tmo - 1'b1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         tmo_cnt_q  <= '0;
         idx_q      <= '0;
         best_q     <= '0;
         cnt_q      <= '0;
         sel_done_q <= 1'b0;
         for (int k = 0; k < NUM_TARGET; k++) begin
            tune_q[k] <= '0;
            pwr_q[k]  <= '0;
         end
         s_val_q    <= '0;
         s_rdy_q    <= '0;
         l_val_q    <= '0;
         trk_q      <= '0;
         locked_q   <= '0;
         ch_err_q   <= '0;
         cfg_pwr_q  <= '0;
         cfg_tune_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (i_start) begin
                  locked_q   <= '0;
                  ch_err_q   <= '0;
                  cfg_pwr_q  <= '0;
                  cfg_tune_q <= '0;
                  trk_q      <= '0;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  busy_q     <= 1'b1;
                  ptr_q      <= '0;
                  state_q    <= NEXT;
               end
            end
            NEXT: begin
               if (ptr_q >= PW'(NUM_CH)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= |ch_err_q;
                  state_q <= DONE;
               end else if (!i_cfg_ch_en[ch]) begin
                  ptr_q <= ptr_q + 1'b1;
               end else begin
                  s_val_q[ch] <= 1'b1;
                  tmo_cnt_q   <= '0;
                  state_q     <= S_TRIG;
               end
            end
            S_TRIG: begin
               if (i_search_trig_rdy[ch]) begin
                  s_val_q[ch] <= 1'b0;
                  s_rdy_q[ch] <= 1'b1;
                  tmo_cnt_q   <= '0;
                  state_q     <= S_WAIT;
               end else if (tmo_hit) begin
                  s_val_q[ch]  <= 1'b0;
                  ch_err_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_WAIT: begin
               if (i_search_done_val[ch]) begin
                  s_rdy_q[ch] <= 1'b0;
                  cnt_q       <= i_num_peaks[int'(ch)*CW +: CW];
                  for (int k = 0; k < NUM_TARGET; k++) begin
                     tune_q[k] <= in_tune[k];
                     pwr_q[k]  <= in_pwr[k];
                  end
                  idx_q      <= '0;
                  best_q     <= '0;
                  sel_done_q <= 1'b0;
                  state_q    <= SELECT;
               end else if (tmo_hit) begin
                  s_rdy_q[ch]  <= 1'b0;
                  ch_err_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            SELECT: begin
               // cfg is written one cycle ahead of the lock trigger
               if (sel_done_q) begin
                  sel_done_q  <= 1'b0;
                  l_val_q[ch] <= 1'b1;
                  tmo_cnt_q   <= '0;
                  state_q     <= L_TRIG;
               end else if (cnt_bad) begin
                  ch_err_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else begin
                  best_q <= best_d;
                  idx_q  <= idx_q + 1'b1;
                  if (sel_last) begin
                     cfg_tune_q[int'(ch)*DAC_WIDTH +: DAC_WIDTH] <= tune_q[best_d];
                     cfg_pwr_q[int'(ch)*ADC_WIDTH +: ADC_WIDTH]  <= pwr_q[best_d];
                     sel_done_q <= 1'b1;
                  end
               end
            end
            L_TRIG: begin
               if (i_lock_trig_rdy[ch]) begin
                  l_val_q[ch] <= 1'b0;
                  trk_q[ch]   <= 1'b1;
                  tmo_cnt_q   <= '0;
                  state_q     <= L_WAIT;
               end else if (tmo_hit) begin
                  l_val_q[ch]  <= 1'b0;
                  ch_err_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            L_WAIT: begin
               if (i_lock_track_val[ch]) begin
                  locked_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else if (tmo_hit) begin
                  trk_q[ch]    <= 1'b0;
                  ch_err_q[ch] <= 1'b1;
                  ptr_q        <= ptr_q + 1'b1;
                  state_q      <= NEXT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_search_trig_val    = s_val_q;
   assign o_search_done_rdy    = s_rdy_q;
   assign o_lock_trig_val      = l_val_q;
   assign o_lock_track_rdy     = trk_q;
   assign o_cfg_pwr_peak       = cfg_pwr_q;
   assign o_cfg_ring_tune_peak = cfg_tune_q;
   assign o_ch_locked          = locked_q;
   assign o_ch_err             = ch_err_q;
   assign o_busy               = busy_q;
   assign o_done               = done_q;
   assign o_err                = err_q;

endmodule

// File: tb/tb_tuner_multi_seq.sv
// Directed bench for tuner_multi_seq: vector table of whole
// sequences plus hand-written reset/timeout/busy corner cases.
module tb_tuner_multi_seq;

   localparam int NC = 4;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int NT = 8;
   localparam int TW = 16;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              start;
   logic [NC-1:0]     ch_en;
   logic              mode;
   logic [TW-1:0]     tmo;
   logic [NC-1:0]     s_trig_val, s_trig_rdy, s_done_val, s_done_rdy;
   logic [NC-1:0]     l_trig_val, l_trig_rdy, l_track_val, l_track_rdy;
   logic [NC*NT*DW-1:0] peak_tune;
   logic [NC*NT*AW-1:0] peak_pwr;
   logic [NC*CW-1:0]  num_peaks;
   logic [NC*AW-1:0]  cfg_pwr;
   logic [NC*DW-1:0]  cfg_tune;
   logic [NC-1:0]     ch_locked, ch_err;
   logic              busy, done, err;

   tuner_multi_seq #(
      .NUM_CH(NC), .DAC_WIDTH(DW), .ADC_WIDTH(AW),
      .NUM_TARGET(NT), .TMO_WIDTH(TW)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .i_cfg_ch_en(ch_en), .i_cfg_mode(mode), .i_cfg_tmo(tmo),
      .o_search_trig_val(s_trig_val), .i_search_trig_rdy(s_trig_rdy),
      .i_search_done_val(s_done_val), .o_search_done_rdy(s_done_rdy),
      .i_peak_tune(peak_tune), .i_peak_pwr(peak_pwr),
      .i_num_peaks(num_peaks),
      .o_lock_trig_val(l_trig_val), .i_lock_trig_rdy(l_trig_rdy),
      .i_lock_track_val(l_track_val), .o_lock_track_rdy(l_track_rdy),
      .o_cfg_pwr_peak(cfg_pwr), .o_cfg_ring_tune_peak(cfg_tune),
      .o_ch_locked(ch_locked), .o_ch_err(ch_err),
      .o_busy(busy), .o_done(done), .o_err(err)
   );

   typedef struct {
      logic [3:0]            en;
      logic                  mode;
      logic [15:0]           tmo;
      logic [3:0]            stuck;
      logic [3:0][3:0]       npk;
      logic [3:0][3:0][7:0]  tune;
      logic [3:0][3:0][7:0]  pwr;
      logic [3:0][7:0]       x_tune;
      logic [3:0][7:0]       x_pwr;
      logic [3:0]            x_lock;
      logic [3:0]            x_err;
      logic                  x_oerr;
      int                    x_nsrch;
      logic [3:0][1:0]       x_order;
      int                    x_v1;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int order_q[$];
   logic [NC-1:0] prev_sv = '0;
   logic [NC-1:0] lock_seen = '0;
   int v1cnt = 0;
   vec_t v[6];

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      logic [NC-1:0] rise;
      @(negedge clk);
      if (rst_n) begin
         rise = s_trig_val & ~prev_sv;
         for (int c = 0; c < NC; c++)
            if (rise[c]) order_q.push_back(c);
         prev_sv = s_trig_val;
         lock_seen = lock_seen | l_trig_val;
         if (s_trig_val[1]) v1cnt++;
         checks++;
         if (!($onehot0(s_trig_val) && $onehot0(l_trig_val) &&
               $onehot0(s_done_rdy))) begin
            failures++;
            $display("FAIL onehot sv=%b dr=%b lv=%b", s_trig_val,
                     s_done_rdy, l_trig_val);
         end
      end
   endtask

   function automatic vec_t dflt();
      vec_t r;
      r.en = 4'hF; r.mode = 1'b0; r.tmo = '0; r.stuck = '0;
      for (int c = 0; c < 4; c++) begin
         r.npk[c] = 4'd4;
         r.tune[c][0] = 8'd20; r.tune[c][1] = 8'd60;
         r.tune[c][2] = 8'd90; r.tune[c][3] = 8'd120;
         r.pwr[c][0] = 8'd10; r.pwr[c][1] = 8'd40;
         r.pwr[c][2] = 8'd40; r.pwr[c][3] = 8'd5;
         r.x_tune[c] = 8'd60; r.x_pwr[c] = 8'd40;
         r.x_order[c] = 2'(c);
      end
      r.x_lock = 4'hF; r.x_err = '0; r.x_oerr = 1'b0;
      r.x_nsrch = 4; r.x_v1 = 1;
      return r;
   endfunction

   task automatic setup(input vec_t r);
      ch_en = r.en; mode = r.mode; tmo = r.tmo;
      s_trig_rdy = ~r.stuck; s_done_val = '1;
      l_trig_rdy = '1; l_track_val = '1;
      peak_tune = '0; peak_pwr = '0; num_peaks = '0;
      for (int c = 0; c < 4; c++) begin
         num_peaks[c*CW +: CW] = r.npk[c];
         for (int k = 0; k < 4; k++) begin
            peak_tune[(c*NT + k)*DW +: DW] = r.tune[c][k];
            peak_pwr[(c*NT + k)*AW +: AW] = r.pwr[c][k];
         end
      end
      order_q.delete(); lock_seen = '0; v1cnt = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!done && n < 3000) begin
         tick();
         n++;
      end
      chk({nm, "_done"}, 64'(done), 64'd1);
   endtask

   function automatic logic [7:0] pack_order(input int n);
      logic [3:0][1:0] o = '0;
      for (int i = 0; i < n && i < order_q.size() && i < 4; i++)
         o[i] = 2'(order_q[i]);
      return o;
   endfunction

   task automatic run_vec(input int i);
      vec_t r = v[i];
      string p = $sformatf("v%0d", i);
      logic [3:0][1:0] xo = '0;
      setup(r);
      pulse_start();
      chk({p, "_busy"}, 64'(busy), 64'd1);
      wait_done(p);
      chk({p, "_idle"}, 64'(busy), 64'd0);
      chk({p, "_tune"}, 64'(cfg_tune), 64'(r.x_tune));
      chk({p, "_pwr"}, 64'(cfg_pwr), 64'(r.x_pwr));
      chk({p, "_locked"}, 64'(ch_locked), 64'(r.x_lock));
      chk({p, "_cherr"}, 64'(ch_err), 64'(r.x_err));
      chk({p, "_err"}, 64'(err), 64'(r.x_oerr));
      chk({p, "_trk"}, 64'(l_track_rdy), 64'(r.x_lock));
      chk({p, "_lockseen"}, 64'(lock_seen), 64'(r.x_lock));
      chk({p, "_nsrch"}, 64'(order_q.size()), 64'(r.x_nsrch));
      for (int k = 0; k < r.x_nsrch; k++) xo[k] = r.x_order[k];
      chk({p, "_order"}, 64'(pack_order(r.x_nsrch)), 64'(xo));
      chk({p, "_v1cyc"}, 64'(v1cnt), 64'(r.x_v1));
   endtask

   initial begin
      int n;
      start = 1'b0;
      setup(dflt());

      for (int i = 0; i < 6; i++) v[i] = dflt();
      v[1].mode = 1'b1;
      v[1].npk[1] = 4'd2;
      v[1].tune[1][0] = 8'd33; v[1].tune[1][1] = 8'd77;
      v[1].pwr[1][0] = 8'd5;   v[1].pwr[1][1] = 8'd50;
      for (int c = 0; c < 4; c++) begin
         v[1].x_tune[c] = 8'd20; v[1].x_pwr[c] = 8'd10;
      end
      v[1].x_tune[1] = 8'd33; v[1].x_pwr[1] = 8'd5;
      v[2].en = 4'b0101;
      v[2].x_tune[1] = '0; v[2].x_pwr[1] = '0;
      v[2].x_tune[3] = '0; v[2].x_pwr[3] = '0;
      v[2].x_lock = 4'b0101; v[2].x_nsrch = 2;
      v[2].x_order[1] = 2'd2; v[2].x_v1 = 0;
      v[3].npk[2] = 4'd0;
      v[3].x_tune[2] = '0; v[3].x_pwr[2] = '0;
      v[3].x_lock = 4'b1011; v[3].x_err = 4'b0100; v[3].x_oerr = 1'b1;
      v[4].tmo = 16'd50; v[4].stuck = 4'b0010;
      v[4].x_tune[1] = '0; v[4].x_pwr[1] = '0;
      v[4].x_lock = 4'b1101; v[4].x_err = 4'b0010; v[4].x_oerr = 1'b1;
      v[4].x_v1 = 50;
      v[5].tune[0][0] = 8'd11; v[5].tune[0][1] = 8'd22;
      v[5].tune[0][2] = 8'd33; v[5].tune[0][3] = 8'd44;
      v[5].pwr[0][0] = 8'd1; v[5].pwr[0][1] = 8'd2;
      v[5].pwr[0][2] = 8'd3; v[5].pwr[0][3] = 8'd9;
      v[5].x_tune[0] = 8'd44; v[5].x_pwr[0] = 8'd9;
      v[5].npk[1] = 4'd1;
      v[5].x_tune[1] = 8'd20; v[5].x_pwr[1] = 8'd10;
      v[5].npk[3] = 4'd9;
      v[5].x_tune[3] = '0; v[5].x_pwr[3] = '0;
      v[5].x_lock = 4'b0111; v[5].x_err = 4'b1000; v[5].x_oerr = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_ctl", 64'({s_trig_val, s_done_rdy, l_trig_val, l_track_rdy,
          ch_locked, ch_err, busy, done, err}), 64'd0);
      chk("rst_cfg", 64'({cfg_tune, cfg_pwr}), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(i);

      // second start while busy must not restart the sequence
      setup(dflt());
      pulse_start();
      repeat (6) tick();
      chk("busy_mid", 64'(busy), 64'd1);
      pulse_start();
      wait_done("ign");
      chk("ign_nsrch", 64'(order_q.size()), 64'd4);
      chk("ign_locked", 64'(ch_locked), 64'hF);

      // ready arrives on the very cycle the timeout would fire
      begin
         vec_t r = dflt();
         r.tmo = 16'd5; r.stuck = 4'b0010;
         setup(r);
      end
      pulse_start();
      n = 0;
      while (!s_trig_val[1] && n < 500) begin
         tick();
         n++;
      end
      chk("tie_seen", 64'(s_trig_val[1]), 64'd1);
      repeat (4) tick();
      chk("tie_val_held", 64'(s_trig_val[1]), 64'd1);
      s_trig_rdy = '1;
      wait_done("tie");
      chk("tie_cherr", 64'(ch_err), 64'd0);
      chk("tie_locked", 64'(ch_locked), 64'hF);
      chk("tie_v1cyc", 64'(v1cnt), 64'd5);

      // async reset while ch1 sits in lock trigger
      setup(dflt());
      l_trig_rdy = 4'b1101;
      pulse_start();
      n = 0;
      while (!l_trig_val[1] && n < 500) begin
         tick();
         n++;
      end
      chk("rst_seen", 64'(l_trig_val), 64'h2);
      chk("rst_pre_cfg", 64'(cfg_tune[15:8]), 64'd60);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ctl", 64'({s_trig_val, s_done_rdy, l_trig_val, l_track_rdy,
          ch_locked, ch_err, busy, done, err}), 64'd0);
      chk("arst_cfg", 64'({cfg_tune, cfg_pwr}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      setup(dflt());
      tick();
      pulse_start();
      wait_done("rst2");
      chk("rst2_order", 64'(pack_order(4)), 64'(8'b11_10_01_00));
      chk("rst2_locked", 64'(ch_locked), 64'hF);
      chk("rst2_tune", 64'(cfg_tune), 64'h3C3C3C3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
